// File: rtl/seq_adder_slicer.sv
// seq_adder_slicer
//   Multi-cycle W-bit adder controller driving an external N-bit ripple adder slice.
//   An operand pair is accepted over valid/ready, presented to the slice N bits per
//   cycle (LSB slice first) with the carry registered between passes, and the
//   assembled W-bit sum plus carry-out is returned over valid/ready.
//   P = W/N passes; W must be an integer multiple of N (W == N is legal, P = 1).
//
// Optional feature (macro SEQ_ADD_OVF_EN):
//   Adds out_ovf, the two's-complement overflow of the W-bit add, taken from the
//   final pass and registered alongside out_sum.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     operand handshake
//   in_a, in_b, in_cin    W-bit operands and carry-in
//   add_a, add_b, add_cin slice operands to the external adder (zero outside RUN)
//   add_s, add_cout       slice result from the external adder (combinational)
//   out_valid/out_ready   result handshake
//   out_sum, out_cout     W-bit sum and carry-out
//   out_ovf               signed overflow (SEQ_ADD_OVF_EN only)

module seq_adder_slicer #(
    parameter int unsigned W = 32,
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_s,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
`ifdef SEQ_ADD_OVF_EN
    output logic         out_cout,
    output logic         out_ovf
`else
    output logic         out_cout
`endif
);

    localparam int unsigned P      = W / N;
    localparam int unsigned KW     = (P > 1) ? $clog2(P) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(P - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [KW-1:0] k_q, k_d;
    logic          in_ready_q, out_valid_q, run_q;
`ifdef SEQ_ADD_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    // Next sum register value: new slice enters at the top, earlier slices move down.
    logic [W-1:0]  sum_shift;
    if (W == N) begin : g_single
        assign sum_shift = add_s;
    end else begin : g_multi
        assign sum_shift = {add_s, sum_q[W-1:N]};
    end

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            run_q       <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            k_q         <= k_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            run_q       <= (state_d == RUN);
`ifdef SEQ_ADD_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        k_d     = k_q;
`ifdef SEQ_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sum_shift;
                carry_d = add_cout;
                a_d     = a_q >> N;
                b_d     = b_q >> N;
                k_d     = k_q + KW'(1);
`ifdef SEQ_ADD_OVF_EN
                // Only the last pass sees the operand MSBs; earlier values are overwritten.
                ovf_d   = (a_q[N-1] == b_q[N-1]) && (add_s[N-1] != a_q[N-1]);
`endif
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slice drive is forced to zero outside RUN.
    assign add_a     = run_q ? a_q[N-1:0] : '0;
    assign add_b     = run_q ? b_q[N-1:0] : '0;
    assign add_cin   = run_q & carry_q;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
`ifdef SEQ_ADD_OVF_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_seq_adder_slicer.sv
// Bench for seq_adder_slicer (W=32, N=8) with a behavioural 8-bit ripple adder.
// The driver pushes hand-computed expected results into a queue; a monitor pops
// and compares whenever a result is handed off.

module tb_seq_adder_slicer;

    localparam int unsigned W = 32;
    localparam int unsigned N = 8;
    localparam int unsigned P = W / N;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [31:0]  acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic [N-1:0] add_a, add_b, add_s;
    logic         add_cin, add_cout;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef SEQ_ADD_OVF_EN
    logic         out_ovf;
`endif

    int           n_pass = 0;
    int           n_total = 0;
    logic [31:0]  cyc = '0;
    exp_t         sb[$];
    logic         prev_v = 1'b0;

    seq_adder_slicer #(.W(W), .N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
`ifdef SEQ_ADD_OVF_EN
        .out_cout (out_cout),
        .out_ovf  (out_ovf)
`else
        .out_cout (out_cout)
`endif
    );

    // Behavioural 8-bit ripple adder slice.
    assign {add_cout, add_s} = 9'(add_a) + 9'(add_b) + 9'(add_cin);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Monitor: latency on result rise, payload compare on each handoff.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) check("unexpected_valid", 64'(out_valid), 64'd0);
                else                check("latency", 64'(cyc - sb[0].acc), 64'(P + 1));
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("sum",  64'(out_sum),  64'(e.sum));
                check("cout", 64'(out_cout), 64'(e.cout));
`ifdef SEQ_ADD_OVF_EN
                check("ovf",  64'(out_ovf),  64'(e.ovf));
`endif
            end
            prev_v = out_valid;
        end
    end

    // Offer an operand pair; returns the accept cycle. keep leaves in_valid high.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input logic keep, output logic [31:0] acc);
        int wait_n;
        exp_t e;
        @(posedge clk); #1;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        wait_n = 0;
        while (!in_ready && wait_n < 100) begin
            @(posedge clk); #1;
            wait_n++;
        end
        acc = cyc;
        if (!in_ready) begin
            check("send_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            e.sum = es; e.cout = ec; e.ovf = eo; e.acc = acc;
            sb.push_back(e);
            if (!keep) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] acc1, acc2;
        int n;

        // Reset values
        #1 rst_n = 1'b0;
        #3;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_cout",  64'(out_cout),  64'd0);
        check("rst_add",       64'({add_a, add_b, add_cin}), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // 1 + 2: also look at the first slice on the adder in cycle 1
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0, acc1);
        check("slice0_a",   64'(add_a),   64'h01);
        check("slice0_b",   64'(add_b),   64'h02);
        check("slice0_cin", 64'(add_cin), 64'd0);
        drain();

        // All-ones + 0 + cin ripples through every pass
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, acc1);
        check("slice0_cin1", 64'(add_cin), 64'd1);
        drain();

        // Signed overflow case
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, acc1);
        drain();

        // Result held under back-pressure
        out_ready = 1'b0;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, acc1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_sum",      64'(out_sum),   64'h2345_6789);
            check("hold_in_ready", 64'(in_ready),  64'd0);
            check("hold_valid",    64'(out_valid), 64'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_in_ready",  64'(in_ready),  64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);
        drain();

        // in_valid held high while busy: second pair waits; throughput P+2
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, acc1);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, acc2);
        check("throughput", 64'(acc2 - acc1), 64'(P + 2));
        drain();

        // Reset in cycle 3 of RUN aborts without a result
        send(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 32'hDEAD_BEF0, 1'b0, 1'b0, 1'b0, acc1);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_valid", 64'(out_valid), 64'd0);
        end
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, acc1);
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
